score_display_ctrl: RTL and testbench

Game-score controller and scoreboard-glyph scheduler for the pong display path. It does three jobs:
- Keeps both players' scores from point pulses raised by the ball logic.
- Sequences serve/play/point/game-over with a small state machine.
- Time-shares one `scoreboard` glyph renderer between the left and right score digits by mapping the 160x120 VGA pixel position into 8x8 digit windows.

Displayed scores only change on a frame boundary, so a digit never tears mid-frame.

---
 rtl/pong_pkg.sv | 32 +++
 rtl/digit_window.sv | 40 ++++
 rtl/score_display_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_score_display_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared types and constants for the pong display path:
//               game FSM encoding, screen geometry, glyph size.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Game sequencing states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  // Visible screen size in pixels
  localparam int H_PIX    = 160;
  localparam int V_PIX    = 120;

  // Score digits are square glyphs of this many pixels per side
  localparam int GLYPH_SZ = 8;

  // Saturating score increment: never moves past the winning score
  function automatic logic [3:0] sat_inc(input logic [3:0] value,
                                         input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage : pong_pkg
`default_nettype wire

// File: rtl/digit_window.sv
`default_nettype none
// ============================================================================
// Module      : digit_window
// Description : Combinational range check of the current pixel against one
//               8x8 digit window, plus the pixel's offset inside it.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_window
  import pong_pkg::*;
#(
  parameter int X0 = 64,
  parameter int Y0 = 4
) (
  input  logic [7:0] px,
  input  logic [6:0] py,
  output logic       hit,
  output logic [2:0] lx,
  output logic [2:0] ly
);

  localparam logic [7:0] c_x0     = 8'(X0);
  localparam logic [6:0] c_y0     = 7'(Y0);
  localparam logic [7:0] c_span_x = 8'(GLYPH_SZ);
  localparam logic [6:0] c_span_y = 7'(GLYPH_SZ);

  logic [7:0] w_dx;
  logic [6:0] w_dy;

  // Full-width offsets are range-checked first; only then cut to 3 bits
  always_comb begin
    w_dx = px - c_x0;
    w_dy = py - c_y0;
    hit  = (px >= c_x0) && (w_dx < c_span_x) &&
           (py >= c_y0) && (w_dy < c_span_y);
    lx   = w_dx[2:0];
    ly   = w_dy[2:0];
  end

endmodule : digit_window
`default_nettype wire

// File: rtl/score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : score_display_ctrl
// Description : Pong score keeper and game sequencer. Shares one scoreboard
//               glyph renderer between the left and right score digits and
//               only updates displayed scores on frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module score_display_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_FRAMES = 60,
  parameter int LX0         = 64,
  parameter int RX0         = 88,
  parameter int DY0         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic [7:0] px,
  input  logic [6:0] py,
  input  logic       frame_start,
  input  logic       point_l,
  input  logic       point_r,
  input  logic       serve_btn,
  input  logic [2:0] glyph_dout,
  output logic [3:0] glyph_score,
  output logic [2:0] glyph_x,
  output logic [2:0] glyph_y,
  output logic [2:0] score_rgb,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       ball_run,
  output logic       game_over,
  output logic       winner
);

  // Hold counter runs 0..HOLD_FRAMES-1
  localparam int                 c_cnt_w     = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_FRAMES - 1);
  localparam logic [3:0]         c_win       = 4'(WIN_SCORE);

  game_state_e        state_q,       state_d;
  logic [3:0]         pend_l_q,      pend_l_d;
  logic [3:0]         pend_r_q,      pend_r_d;
  logic [c_cnt_w-1:0] frame_cnt_q,   frame_cnt_d;
  logic               winner_q,      winner_d;
  logic [3:0]         score_l_q,     score_l_d;
  logic [3:0]         score_r_q,     score_r_d;
  logic [3:0]         glyph_score_q, glyph_score_d;
  logic [2:0]         glyph_x_q,     glyph_x_d;
  logic [2:0]         glyph_y_q,     glyph_y_d;
  logic               in_win_q,      in_win_d;
  logic [2:0]         score_rgb_q,   score_rgb_d;

  logic               w_l_hit, w_r_hit;
  logic [2:0]         w_l_x, w_l_y, w_r_x, w_r_y;

  digit_window #(
    .X0 (LX0),
    .Y0 (DY0)
  ) u_win_l (
    .px  (px),
    .py  (py),
    .hit (w_l_hit),
    .lx  (w_l_x),
    .ly  (w_l_y)
  );

  digit_window #(
    .X0 (RX0),
    .Y0 (DY0)
  ) u_win_r (
    .px  (px),
    .py  (py),
    .hit (w_r_hit),
    .lx  (w_r_x),
    .ly  (w_r_y)
  );

  // Game FSM: serve / play / point hold / game over, plus pending scores
  always_comb begin
    state_d     = state_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    frame_cnt_d = frame_cnt_q;
    winner_d    = winner_q;

    case (state_q)
      ST_SERVE: begin
        if (serve_btn) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // A simultaneous double point is treated as noise and dropped
        if (point_l ^ point_r) begin
          if (point_l) begin
            pend_l_d = sat_inc(pend_l_q, c_win);
          end else begin
            pend_r_d = sat_inc(pend_r_q, c_win);
          end
          frame_cnt_d = '0;
          state_d     = ST_POINT;
        end
      end

      ST_POINT: begin
        if (frame_start) begin
          if (frame_cnt_q == c_hold_last) begin
            frame_cnt_d = '0;
            if ((pend_l_q == c_win) || (pend_r_q == c_win)) begin
              state_d  = ST_OVER;
              winner_d = (pend_r_q == c_win);
            end else begin
              state_d  = ST_SERVE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      ST_OVER: begin
        if (serve_btn) begin
          state_d  = ST_SERVE;
          pend_l_d = '0;
          pend_r_d = '0;
        end
      end

      default: begin
        state_d = ST_SERVE;
      end
    endcase
  end

  // Displayed scores follow the pending ones only at frame start (no tearing)
  always_comb begin
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if (frame_start) begin
      score_l_d = pend_l_q;
      score_r_d = pend_r_q;
    end
  end

  // Glyph request mux on pixel strobes; colour gated by the delayed window flag
  always_comb begin
    glyph_score_d = glyph_score_q;
    glyph_x_d     = glyph_x_q;
    glyph_y_d     = glyph_y_q;
    in_win_d      = in_win_q;
    score_rgb_d   = in_win_q ? glyph_dout : 3'd0;

    if (pix_en) begin
      if (w_l_hit) begin
        glyph_score_d = score_l_q;
        glyph_x_d     = w_l_x;
        glyph_y_d     = w_l_y;
        in_win_d      = 1'b1;
      end else if (w_r_hit) begin
        glyph_score_d = score_r_q;
        glyph_x_d     = w_r_x;
        glyph_y_d     = w_r_y;
        in_win_d      = 1'b1;
      end else begin
        glyph_score_d = '0;
        glyph_x_d     = '0;
        glyph_y_d     = '0;
        in_win_d      = 1'b0;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_SERVE;
      pend_l_q      <= '0;
      pend_r_q      <= '0;
      frame_cnt_q   <= '0;
      winner_q      <= 1'b0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      glyph_score_q <= '0;
      glyph_x_q     <= '0;
      glyph_y_q     <= '0;
      in_win_q      <= 1'b0;
      score_rgb_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_l_q      <= pend_l_d;
      pend_r_q      <= pend_r_d;
      frame_cnt_q   <= frame_cnt_d;
      winner_q      <= winner_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      glyph_score_q <= glyph_score_d;
      glyph_x_q     <= glyph_x_d;
      glyph_y_q     <= glyph_y_d;
      in_win_q      <= in_win_d;
      score_rgb_q   <= score_rgb_d;
    end
  end

  assign glyph_score = glyph_score_q;
  assign glyph_x     = glyph_x_q;
  assign glyph_y     = glyph_y_q;
  assign score_rgb   = score_rgb_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign ball_run    = (state_q == ST_PLAY);
  assign game_over   = (state_q == ST_OVER);
  assign winner      = winner_q;

endmodule : score_display_ctrl
`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display_ctrl
// Description : Self-checking bench for score_display_ctrl: directed game
//               sequences, a pixel-window vector table, and a randomized run
//               against a behavioural game/display model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display_ctrl;

  localparam int WIN  = 9;
  localparam int HOLD = 2;
  localparam int LX0  = 64;
  localparam int RX0  = 88;
  localparam int DY0  = 4;

  localparam int M_SERVE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_POINT = 2;
  localparam int M_OVER  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic [7:0] px = '0;
  logic [6:0] py = '0;
  logic       frame_start = 1'b0;
  logic       point_l = 1'b0;
  logic       point_r = 1'b0;
  logic       serve_btn = 1'b0;
  logic [2:0] glyph_dout = '0;
  logic [3:0] glyph_score;
  logic [2:0] glyph_x;
  logic [2:0] glyph_y;
  logic [2:0] score_rgb;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       ball_run;
  logic       game_over;
  logic       winner;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_mode = M_SERVE;
  int m_pend[2];
  int m_disp[2];
  int m_frames = 0;
  int m_win = 0;
  int m_gs = 0, m_gx = 0, m_gy = 0, m_inwin = 0, m_rgb = 0;

  typedef struct {
    int px;
    int py;
    int dout;
    int gs;
    int gx;
    int gy;
    int rgb;
  } pix_vec_t;

  score_display_ctrl #(
    .WIN_SCORE   (WIN),
    .HOLD_FRAMES (HOLD),
    .LX0         (LX0),
    .RX0         (RX0),
    .DY0         (DY0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .px          (px),
    .py          (py),
    .frame_start (frame_start),
    .point_l     (point_l),
    .point_r     (point_r),
    .serve_btn   (serve_btn),
    .glyph_dout  (glyph_dout),
    .glyph_score (glyph_score),
    .glyph_x     (glyph_x),
    .glyph_y     (glyph_y),
    .score_rgb   (score_rgb),
    .score_l     (score_l),
    .score_r     (score_r),
    .ball_run    (ball_run),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Which digit window (0 none, 1 left, 2 right) a pixel lands in, and its offset
  function automatic void win_lookup(input int x, input int y,
                                     output int side, output int lx, output int ly);
    side = 0; lx = 0; ly = 0;
    if (y >= DY0 && y < DY0 + 8) begin
      if (x >= LX0 && x < LX0 + 8) begin
        side = 1; lx = x - LX0; ly = y - DY0;
      end else if (x >= RX0 && x < RX0 + 8) begin
        side = 2; lx = x - RX0; ly = y - DY0;
      end
    end
  endfunction

  // Advance the model by one clock using the inputs presented before the edge
  task automatic model_edge();
    int side, lx, ly;
    if (reset) begin
      m_mode = M_SERVE; m_pend[0] = 0; m_pend[1] = 0; m_disp[0] = 0; m_disp[1] = 0;
      m_frames = 0; m_win = 0; m_gs = 0; m_gx = 0; m_gy = 0; m_inwin = 0; m_rgb = 0;
      return;
    end
    m_rgb = (m_inwin != 0) ? int'(glyph_dout) : 0;
    if (pix_en) begin
      win_lookup(int'(px), int'(py), side, lx, ly);
      m_inwin = (side != 0) ? 1 : 0;
      m_gs = (side == 1) ? m_disp[0] : (side == 2) ? m_disp[1] : 0;
      m_gx = lx;
      m_gy = ly;
    end
    if (frame_start) begin
      m_disp[0] = m_pend[0];
      m_disp[1] = m_pend[1];
    end
    case (m_mode)
      M_SERVE: if (serve_btn) m_mode = M_PLAY;
      M_PLAY: begin
        if (point_l != point_r) begin
          int s;
          s = point_l ? 0 : 1;
          m_pend[s] = (m_pend[s] + 1 > WIN) ? WIN : m_pend[s] + 1;
          m_frames = 0;
          m_mode = M_POINT;
        end
      end
      M_POINT: begin
        if (frame_start) begin
          m_frames++;
          if (m_frames == HOLD) begin
            if (m_pend[0] == WIN || m_pend[1] == WIN) begin
              m_mode = M_OVER;
              m_win = (m_pend[1] == WIN) ? 1 : 0;
            end else begin
              m_mode = M_SERVE;
            end
          end
        end
      end
      default: begin
        if (serve_btn) begin
          m_mode = M_SERVE; m_pend[0] = 0; m_pend[1] = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("ball_run",    int'(ball_run),    int'(m_mode == M_PLAY));
    chk("game_over",   int'(game_over),   int'(m_mode == M_OVER));
    if (m_mode == M_OVER) chk("winner", int'(winner), m_win);
    chk("score_l",     int'(score_l),     m_disp[0]);
    chk("score_r",     int'(score_r),     m_disp[1]);
    chk("glyph_score", int'(glyph_score), m_gs);
    chk("glyph_x",     int'(glyph_x),     m_gx);
    chk("glyph_y",     int'(glyph_y),     m_gy);
    chk("score_rgb",   int'(score_rgb),   m_rgb);
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    pix_en = ~pix_en;
  endtask

  task automatic frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
  endtask

  task automatic serve();
    serve_btn = 1'b1; tick(); serve_btn = 1'b0;
  endtask

  // From PLAY: score one point, sit out the hold, and re-serve unless game over
  task automatic play_point(input bit l, input bit r);
    point_l = l; point_r = r; tick(); point_l = 1'b0; point_r = 1'b0;
    for (int f = 0; f < HOLD; f++) frame();
    if (m_mode == M_SERVE) serve();
  endtask

  pix_vec_t vecs[13];

  initial begin
    // Expected glyph_score assumes displayed scores left=2, right=3
    vecs[0]  = '{66,  5,  5, 2, 2, 1, 5};
    vecs[1]  = '{90,  11, 6, 3, 2, 7, 6};
    vecs[2]  = '{72,  5,  7, 0, 0, 0, 0};
    vecs[3]  = '{64,  4,  3, 2, 0, 0, 3};
    vecs[4]  = '{71,  11, 1, 2, 7, 7, 1};
    vecs[5]  = '{71,  12, 4, 0, 0, 0, 0};
    vecs[6]  = '{63,  8,  2, 0, 0, 0, 0};
    vecs[7]  = '{95,  4,  7, 3, 7, 0, 7};
    vecs[8]  = '{96,  4,  5, 0, 0, 0, 0};
    vecs[9]  = '{88,  3,  6, 0, 0, 0, 0};
    vecs[10] = '{80,  6,  7, 0, 0, 0, 0};
    vecs[11] = '{159, 119, 7, 0, 0, 0, 0};
    vecs[12] = '{89,  10, 4, 3, 1, 6, 4};

    // Reset state
    reset = 1'b1; tick(); tick();
    chk("rst_score_l", int'(score_l), 0);
    chk("rst_score_r", int'(score_r), 0);
    chk("rst_glyph", int'({glyph_score, glyph_x, glyph_y}), 0);
    chk("rst_rgb", int'(score_rgb), 0);
    chk("rst_ball_run", int'(ball_run), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_winner", int'(winner), 0);
    reset = 1'b0;

    // Serve starts play one cycle later
    serve();
    chk("serve_ball_run", int'(ball_run), 1);

    // Left point, two-frame hold
    point_l = 1'b1; tick(); point_l = 1'b0;
    chk("pt_ball_run_low", int'(ball_run), 0);
    chk("pt_disp_not_yet", int'(score_l), 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("pt_disp_after_frame", int'(score_l), 1);
    serve();
    chk("hold_ignores_serve", int'(ball_run), 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("hold_done_not_over", int'(game_over), 0);
    serve();
    chk("hold_done_serve", int'(ball_run), 1);

    // Simultaneous points are ignored
    point_l = 1'b1; point_r = 1'b1; tick(); point_l = 1'b0; point_r = 1'b0;
    chk("both_stay_play", int'(ball_run), 1);
    frame();
    chk("both_no_l", int'(score_l), 1);
    chk("both_no_r", int'(score_r), 0);

    // Frame start coincident with a point shows the pre-point score
    point_l = 1'b1; frame_start = 1'b1; tick(); point_l = 1'b0; frame_start = 1'b0;
    chk("same_cycle_pre", int'(score_l), 1);
    frame();
    chk("same_cycle_next", int'(score_l), 2);
    frame();
    serve();

    // Left wins at 9
    for (int i = 0; i < WIN - 2; i++) play_point(1'b1, 1'b0);
    chk("over_flag", int'(game_over), 1);
    chk("over_winner", int'(winner), 0);
    chk("over_score_l", int'(score_l), WIN);
    point_r = 1'b1; tick(); point_r = 1'b0;
    frame();
    chk("over_ignore_r", int'(score_r), 0);
    chk("over_stays", int'(game_over), 1);
    serve();
    chk("over_cleared", int'(game_over), 0);
    frame();
    chk("clear_score_l", int'(score_l), 0);
    chk("clear_score_r", int'(score_r), 0);

    // Set up displayed scores left=2, right=3
    serve();
    for (int i = 0; i < 3; i++) play_point(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) play_point(1'b1, 1'b0);

    // Pixel window table
    for (int i = 0; i < 13; i++) begin
      if (!pix_en) tick();
      px = 8'(vecs[i].px);
      py = 7'(vecs[i].py);
      glyph_dout = 3'(vecs[i].dout);
      tick();
      chk("tbl_glyph_score", int'(glyph_score), vecs[i].gs);
      chk("tbl_glyph_x", int'(glyph_x), vecs[i].gx);
      chk("tbl_glyph_y", int'(glyph_y), vecs[i].gy);
      tick();
      chk("tbl_score_rgb", int'(score_rgb), vecs[i].rgb);
    end

    // Reset in the middle of a point hold
    px = 8'd66; py = 7'd5; glyph_dout = 3'd7;
    serve();
    point_r = 1'b1; tick(); point_r = 1'b0;
    frame();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_score_l", int'(score_l), 0);
    chk("midrst_score_r", int'(score_r), 0);
    chk("midrst_rgb", int'(score_rgb), 0);
    chk("midrst_ball_run", int'(ball_run), 0);
    serve();
    chk("midrst_serve", int'(ball_run), 1);

    // Randomized run against the model
    for (int c = 0; c < 8000; c++) begin
      point_l     = ($urandom_range(0, 19) == 0);
      point_r     = ($urandom_range(0, 19) == 0);
      frame_start = ($urandom_range(0, 11) == 0);
      serve_btn   = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 2999) == 0);
      px          = 8'($urandom_range(56, 100));
      py          = 7'($urandom_range(0, 15));
      glyph_dout  = 3'($urandom_range(0, 7));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_score_display_ctrl
`default_nettype wire
